// File: rtl/mem_scan_pkg.sv
// Shared types for mem_scan_ctrl: FSM state encoding, display word layout and the fill pattern.
package mem_scan_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FILL   = 3'd1,
      S_RD_REQ = 3'd2,
      S_RD_CAP = 3'd3,
      S_DWELL  = 3'd4
   } state_e;

   // Display stage expects the low address byte in the upper half.
   typedef struct packed {
      logic [7:0]        addr_lo;
      logic [DATA_W-1:0] data;
   } disp_word_t;

   function automatic logic [DATA_W-1:0] fill_pattern(input logic [7:0]        addr_lo,
                                                      input logic [DATA_W-1:0] seed);
      return addr_lo ^ seed;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that holds the scan FSM in its dwell state: load arms it, count steps it, done flags zero.
module dwell_timer #(
   parameter int unsigned DWELL = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic count,
   output logic done
);

   localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Loading DWELL-1 and exiting on zero gives exactly DWELL counting cycles.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CNT_W'(DWELL - 1);
      end else if (count && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_scan_ctrl.sv
// Fills NUM_WORDS memory words with (addr[7:0] ^ SEED), then scans them forever onto disp_word.
// Build macro MEM_SCAN_CTRL_CHECK_EN adds a sticky err output flagging read-back mismatches.
module mem_scan_ctrl
   import mem_scan_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFF00,
   parameter int unsigned       NUM_WORDS = 16,
   parameter logic [DATA_W-1:0] SEED      = 8'hED,
   parameter int unsigned       DWELL     = 25_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              write_enable,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] DI,
   input  logic [DATA_W-1:0] DO,
   output logic [15:0]       disp_word,
   output logic              disp_valid,
   output logic              busy
`ifdef MEM_SCAN_CTRL_CHECK_EN
   ,
   output logic              err
`endif
);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  i_q, i_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] di_q, di_d;
   disp_word_t        disp_q, disp_d;
   logic              dv_q, dv_d;
   logic              busy_q, busy_d;
`ifdef MEM_SCAN_CTRL_CHECK_EN
   logic              err_q, err_d;
`endif

   logic              last_c;
   logic [IDX_W-1:0]  nxt_i_c;
   logic [ADDR_W-1:0] nxt_addr_c;
   logic              load_c;
   logic              count_c;
   logic              done_c;

   dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell_timer (
      .clk   (clk),
      .reset (reset),
      .load  (load_c),
      .count (count_c),
      .done  (done_c)
   );

   // Word index wraps after the last word; the address wraps modulo 2^16 on its own.
   assign last_c     = (i_q == IDX_W'(NUM_WORDS - 1));
   assign nxt_i_c    = last_c ? '0 : (i_q + IDX_W'(1));
   assign nxt_addr_c = BASE_ADDR + ADDR_W'(nxt_i_c);

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      di_d    = di_q;
      disp_d  = disp_q;
      dv_d    = dv_q;
      load_c  = 1'b0;
      count_c = 1'b0;
`ifdef MEM_SCAN_CTRL_CHECK_EN
      err_d   = err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FILL;
               i_d     = '0;
               we_d    = 1'b1;
               addr_d  = BASE_ADDR;
               di_d    = fill_pattern(BASE_ADDR[7:0], SEED);
            end
         end

         S_FILL: begin
            i_d    = nxt_i_c;
            addr_d = nxt_addr_c;
            if (last_c) begin
               state_d = S_RD_REQ;
            end else begin
               we_d = 1'b1;
               di_d = fill_pattern(nxt_addr_c[7:0], SEED);
            end
         end

         S_RD_REQ: begin
            state_d = S_RD_CAP;
         end

         // DO now holds the word addressed during RD_REQ.
         S_RD_CAP: begin
            disp_d.addr_lo = addr_q[7:0];
            disp_d.data    = DO;
            dv_d           = 1'b1;
            load_c         = 1'b1;
            state_d        = S_DWELL;
`ifdef MEM_SCAN_CTRL_CHECK_EN
            if (DO != fill_pattern(addr_q[7:0], SEED)) begin
               err_d = 1'b1;
            end
`endif
         end

         S_DWELL: begin
            count_c = 1'b1;
            if (done_c) begin
               state_d = S_RD_REQ;
               i_d     = nxt_i_c;
               addr_d  = nxt_addr_c;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         we_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         di_q    <= '0;
         disp_q  <= '0;
         dv_q    <= 1'b0;
         busy_q  <= 1'b0;
`ifdef MEM_SCAN_CTRL_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         di_q    <= di_d;
         disp_q  <= disp_d;
         dv_q    <= dv_d;
         busy_q  <= busy_d;
`ifdef MEM_SCAN_CTRL_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   assign write_enable = we_q;
   assign addr         = addr_q;
   assign DI           = di_q;
   assign disp_word    = disp_q;
   assign disp_valid   = dv_q;
   assign busy         = busy_q;
`ifdef MEM_SCAN_CTRL_CHECK_EN
   assign err          = err_q;
`endif

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Bench for mem_scan_ctrl: two instances (bases FF0C and FFFE) against a cycle-count model and synchronous memories.
module tb_mem_scan_ctrl;

   localparam logic [15:0] BASE0 = 16'hFF0C;
   localparam logic [15:0] BASE1 = 16'hFFFE;
   localparam int unsigned N     = 4;
   localparam logic [7:0]  SEED  = 8'hED;
   localparam int unsigned DW    = 3;
   localparam int          P     = DW + 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        corrupt;

   logic        we_w   [2];
   logic [15:0] addr_w [2];
   logic [7:0]  di_w   [2];
   logic [7:0]  do_w   [2];
   logic [15:0] dw_w   [2];
   logic        dv_w   [2];
   logic        busy_w [2];
`ifdef MEM_SCAN_CTRL_CHECK_EN
   logic        err_w  [2];
`endif

   always #5 clk = ~clk;

   mem_scan_ctrl #(.BASE_ADDR(BASE0), .NUM_WORDS(N), .SEED(SEED), .DWELL(DW)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .write_enable(we_w[0]), .addr(addr_w[0]),
      .DI(di_w[0]), .DO(do_w[0]), .disp_word(dw_w[0]), .disp_valid(dv_w[0]), .busy(busy_w[0])
`ifdef MEM_SCAN_CTRL_CHECK_EN
      , .err(err_w[0])
`endif
   );

   mem_scan_ctrl #(.BASE_ADDR(BASE1), .NUM_WORDS(N), .SEED(SEED), .DWELL(DW)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .write_enable(we_w[1]), .addr(addr_w[1]),
      .DI(di_w[1]), .DO(do_w[1]), .disp_word(dw_w[1]), .disp_valid(dv_w[1]), .busy(busy_w[1])
`ifdef MEM_SCAN_CTRL_CHECK_EN
      , .err(err_w[1])
`endif
   );

   // Synchronous-read memories with a write log.
   logic [7:0]  mem0 [0:65535];
   logic [7:0]  mem1 [0:65535];
   logic [23:0] wlog0 [$];
   logic [23:0] wlog1 [$];

   always @(posedge clk) begin
      if (we_w[0]) begin
         mem0[addr_w[0]] <= di_w[0];
         wlog0.push_back({addr_w[0], di_w[0]});
      end
      if (corrupt) mem0[16'hFF0E] <= 8'h00;
      do_w[0] <= mem0[addr_w[0]];
      if (we_w[1]) begin
         mem1[addr_w[1]] <= di_w[1];
         wlog1.push_back({addr_w[1], di_w[1]});
      end
      do_w[1] <= mem1[addr_w[1]];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s[%0d]: got %0h, expected %0h", nm, k, act, exp);
      end
   endtask

   // Model: m_t counts edges since the start edge; fill occupies t<N, then each word takes P cycles.
   bit          chk_en;
   bit          m_run  [2];
   int          m_t    [2];
   logic [15:0] m_disp [2];
   bit          m_dv   [2];
   bit          m_err  [2];
   logic [7:0]  golden [2][N];

   function automatic logic [15:0] waddr(input int k, input int w);
      return ((k == 0) ? BASE0 : BASE1) + 16'(w);
   endfunction

   function automatic logic [7:0] wpat(input int k, input int w);
      logic [15:0] a;
      a = waddr(k, w);
      return a[7:0] ^ SEED;
   endfunction

   function automatic logic [15:0] wdisp(input int k, input int w);
      logic [15:0] a;
      a = waddr(k, w);
      return {a[7:0], golden[k][w]};
   endfunction

   function automatic logic [15:0] exp_addr(input int k);
      if (!m_run[k]) return waddr(k, 0);
      if (m_t[k] < int'(N)) return waddr(k, m_t[k]);
      return waddr(k, ((m_t[k] - int'(N)) / P) % int'(N));
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_run[k]  <= 1'b0;
            m_t[k]    <= 0;
            m_disp[k] <= 16'h0000;
            m_dv[k]   <= 1'b0;
            m_err[k]  <= 1'b0;
         end else if (!m_run[k]) begin
            if (start) begin
               m_run[k] <= 1'b1;
               m_t[k]   <= 0;
               for (int w = 0; w < int'(N); w++) golden[k][w] <= wpat(k, w);
            end
         end else begin
            m_t[k] <= m_t[k] + 1;
            if ((m_t[k] + 1 >= int'(N)) && (((m_t[k] + 1 - int'(N)) % P) == 2)) begin
               m_disp[k] <= wdisp(k, ((m_t[k] + 1 - int'(N)) / P) % int'(N));
               m_dv[k]   <= 1'b1;
               if (golden[k][((m_t[k] + 1 - int'(N)) / P) % int'(N)] !=
                   wpat(k, ((m_t[k] + 1 - int'(N)) / P) % int'(N)))
                  m_err[k] <= 1'b1;
            end
         end
      end
      if (corrupt) golden[0][2] <= 8'h00;
      if (reset) chk_en <= 1'b1;
   end

   // Per-cycle compare plus a log of displayed values for instance 0.
   logic [15:0] dlog_v [$];
   int          dlog_c [$];
   logic [15:0] last0 = 16'h0000;
   int          cyc = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            check("write_enable", k, 32'(we_w[k]), 32'(m_run[k] && (m_t[k] < int'(N))));
            check("addr", k, 32'(addr_w[k]), 32'(exp_addr(k)));
            if (!m_run[k]) check("DI", k, 32'(di_w[k]), 32'd0);
            else if (m_t[k] < int'(N)) check("DI", k, 32'(di_w[k]), 32'(wpat(k, m_t[k])));
            check("disp_word", k, 32'(dw_w[k]), 32'(m_disp[k]));
            check("disp_valid", k, 32'(dv_w[k]), 32'(m_dv[k]));
            check("busy", k, 32'(busy_w[k]), 32'(m_run[k]));
`ifdef MEM_SCAN_CTRL_CHECK_EN
            check("err", k, 32'(err_w[k]), 32'(m_err[k]));
`endif
         end
         if (dv_w[0] && (dw_w[0] !== last0)) begin
            dlog_v.push_back(dw_w[0]);
            dlog_c.push_back(cyc);
         end
         last0 <= dw_w[0];
         cyc   <= cyc + 1;
      end
   end

   logic [23:0] lit0 [4] = '{24'hFF0CE1, 24'hFF0DE0, 24'hFF0EE3, 24'hFF0FE2};
   logic [23:0] lit1 [4] = '{24'hFFFE13, 24'hFFFF12, 24'h0000ED, 24'h0001EC};
   logic [15:0] dlit [4] = '{16'h0CE1, 16'h0DE0, 16'h0EE3, 16'h0FE2};

   task automatic check_reset_outputs();
      check("rst_we", 0, 32'(we_w[0]), 32'd0);
      check("rst_addr", 0, 32'(addr_w[0]), 32'hFF0C);
      check("rst_addr", 1, 32'(addr_w[1]), 32'hFFFE);
      check("rst_DI", 0, 32'(di_w[0]), 32'd0);
      check("rst_disp", 0, 32'(dw_w[0]), 32'd0);
      check("rst_valid", 0, 32'(dv_w[0]), 32'd0);
      check("rst_busy", 0, 32'(busy_w[0]), 32'd0);
      check("rst_busy", 1, 32'(busy_w[1]), 32'd0);
   endtask

   task automatic check_fill_logs();
      check("fill_count", 0, 32'(wlog0.size()), 32'd4);
      check("fill_count", 1, 32'(wlog1.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("fill_write", 0, (i < wlog0.size()) ? 32'(wlog0[i]) : 32'hDEADBEEF, 32'(lit0[i]));
         check("fill_write", 1, (i < wlog1.size()) ? 32'(wlog1[i]) : 32'hDEADBEEF, 32'(lit1[i]));
      end
   endtask

   initial begin
      bit found;
      reset   = 1'b1;
      start   = 1'b0;
      corrupt = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      reset = 1'b0;

      // Fill then scan.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (8) @(negedge clk);
      check_fill_logs();
      repeat (30) @(negedge clk);

      // start during scan must be ignored.
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (25) @(negedge clk);
      check("disp_count", 0, 32'(dlog_v.size() >= 9), 32'd1);
      for (int i = 0; i < dlog_v.size(); i++) begin
         check("disp_seq", i, 32'(dlog_v[i]), 32'(dlit[i % 4]));
         if (i > 0) check("disp_period", i, 32'(dlog_c[i] - dlog_c[i-1]), 32'd5);
      end

      // Reset on the second fill cycle.
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      wlog0.delete(); wlog1.delete();
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      check_reset_outputs();
      check("abort_writes", 0, 32'(wlog0.size()), 32'd2);
      check("abort_writes", 1, 32'(wlog1.size()), 32'd2);
      check("abort_last", 0, (wlog0.size() > 1) ? 32'(wlog0[1]) : 32'hDEADBEEF, 32'h00FF0DE0);
      repeat (3) @(negedge clk);
      check("no_more_writes", 0, 32'(wlog0.size()), 32'd2);
      check("no_more_writes", 1, 32'(wlog1.size()), 32'd2);

      // Refill, then corrupt FF0E right after fill.
      wlog0.delete(); wlog1.delete();
      dlog_v.delete(); dlog_c.delete();
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      found = 1'b0;
      for (int n = 0; (n < 40) && !found; n++) begin
         @(negedge clk);
         if (m_run[0] && (m_t[0] == int'(N))) found = 1'b1;
      end
      check("fill_done_wait", 0, 32'(found), 32'd1);
      if (found) begin
         corrupt = 1'b1;
         @(negedge clk); corrupt = 1'b0;
      end
      repeat (30) @(negedge clk);
      check_fill_logs();
      check("corrupt_count", 0, 32'(dlog_v.size() >= 4), 32'd1);
      check("corrupt_w0", 0, (dlog_v.size() > 0) ? 32'(dlog_v[0]) : 32'hDEADBEEF, 32'h0CE1);
      check("corrupt_w2", 0, (dlog_v.size() > 2) ? 32'(dlog_v[2]) : 32'hDEADBEEF, 32'h0E00);
      check("corrupt_w3", 0, (dlog_v.size() > 3) ? 32'(dlog_v[3]) : 32'hDEADBEEF, 32'h0FE2);
`ifdef MEM_SCAN_CTRL_CHECK_EN
      check("err_sticky", 0, 32'(err_w[0]), 32'd1);
      check("err_clean", 1, 32'(err_w[1]), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_scan_ctrl.md
MEM_SCAN_CTRL -- requirements
Module: mem_scan_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFF00: first memory address filled and scanned.
REQ-002 SHALL have parameter NUM_WORDS, default 16, range 1..256: number of consecutive words handled.
REQ-003 SHALL have parameter SEED, default 8'hED: fill pattern key.
REQ-004 SHALL have parameter DWELL, default 25_000_000, minimum 1: cycles each read value is held on disp_word.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request to begin the fill-then-scan sequence.
REQ-008 SHALL have port write_enable, output, 1 bit: memory write strobe.
REQ-009 SHALL have port addr, output, 16 bits: memory address.
REQ-010 SHALL have port DI, output, 8 bits: memory write data.
REQ-011 SHALL have port DO, input, 8 bits: memory read data, valid one cycle after addr is presented with write_enable low.
REQ-012 SHALL have port disp_word, output, 16 bits: {addr[7:0], data}, fed to the hex/seven-segment display stage.
REQ-013 SHALL have port disp_valid, output, 1 bit: high once disp_word holds a scanned value.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, RD_REQ, RD_CAP, DWELL.
REQ-016 IDLE -> FILL on start=1; start SHALL be ignored in all other states.
REQ-017 FILL: one write per cycle, write_enable=1, addr=BASE_ADDR+i, DI=(BASE_ADDR+i)[7:0] XOR SEED, i=0..NUM_WORDS-1; after the last write -> RD_REQ with i=0.
REQ-018 RD_REQ: write_enable=0, addr=BASE_ADDR+i; next state RD_CAP.
REQ-019 RD_CAP: disp_word <= {addr[7:0], DO}, disp_valid <= 1; next state DWELL.
REQ-020 DWELL: disp_word held for exactly DWELL cycles; then i advances and the FSM returns to RD_REQ.
REQ-021 After i=NUM_WORDS-1, i SHALL wrap to 0 and scanning SHALL continue indefinitely; the FSM returns to IDLE only on reset.
REQ-022 Address arithmetic SHALL be 16-bit modulo 2^16; BASE_ADDR+i crossing 16'hFFFF wraps to 16'h0000.
REQ-023 write_enable SHALL be 1 only in FILL; addr and DI SHALL be registered outputs.
REQ-024 Read-to-display latency: disp_word updates on the clock edge that ends RD_CAP, two cycles after entering RD_REQ.

Reset
REQ-025 On reset=1 at a clock edge: state=IDLE, i=0, write_enable=0, addr=BASE_ADDR, DI=0, disp_word=16'h0000, disp_valid=0, busy=0, err=0 if present.
REQ-026 Reset mid-FILL or mid-scan SHALL abort immediately with no further writes; memory contents already written are left as is.

Configuration
REQ-027 With macro MEM_SCAN_CTRL_CHECK_EN defined: output err (1 bit) SHALL be added; in RD_CAP, if DO != addr[7:0] XOR SEED, err SHALL be set sticky until reset.
REQ-028 Without MEM_SCAN_CTRL_CHECK_EN: port err and the compare logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 State encoding and the disp_word field layout SHALL live in shared package mem_scan_pkg.
REQ-030 The dwell counter SHALL be a sub-module named dwell_timer (load, count, done) instantiated once.

Verification (BASE_ADDR=16'hFF0C, NUM_WORDS=4, SEED=8'hED, DWELL=3, behavioural synchronous-read memory model)
REQ-031 Reset then start pulse -> 4 writes on consecutive cycles: FF0C=E1, FF0D=E0, FF0E=E3, FF0F=E2; write_enable then drops.
REQ-032 After fill -> disp_word sequence 0CE1, 0DE0, 0EE3, 0FE2, 0CE1, ...; each value held 3 cycles plus 2 read cycles; disp_valid rises with the first value.
REQ-033 start pulsed during scan -> no change in sequence or timing.
REQ-034 reset asserted on the 2nd fill cycle -> no further writes, all outputs at reset values the next cycle, a subsequent start refills from FF0C.
REQ-035 With MEM_SCAN_CTRL_CHECK_EN, corrupt model word FF0E to 00 after fill -> err rises at its RD_CAP and stays high.
REQ-036 BASE_ADDR=16'hFFFE, NUM_WORDS=4 -> addresses FFFE, FFFF, 0000, 0001, with DI values 13, 12, ED, EC.
